spi_transceiver: RTL
====================

# spi_transceiver

SPI mode-0 byte engine sitting directly downstream of `clock_divider`. It accepts one byte from the host over a valid/ready handshake, frames it with chip select, and fires the divider's one-cycle start strobe. It then consumes the divider's SCLK output to shift the byte out on MOSI MSB-first while capturing MISO, and returns the received byte with a one-cycle valid pulse.

## Interface
Parameters:
- `CS_SETUP_CYCLES`, default 2: `i_clk` cycles from CS assertion to the start strobe; legal range 1..255.
- `CS_HOLD_CYCLES`, default 2: `i_clk` cycles from divider idle to CS deassertion; legal range 1..255.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_tx_data`  in  8  byte to transmit.
- `i_tx_valid`  in  1  host offers `i_tx_data`.
- `o_tx_ready`  out  1  block can accept a byte.
- `o_rx_data`  out  8  last received byte; held stable until the next `o_rx_valid`.
- `o_rx_valid`  out  1  one-cycle pulse when `o_rx_data` and `o_rx_err` are updated.
- `o_rx_err`  out  1  valid only with `o_rx_valid`; 1 means the transfer did not see exactly 8 SCLK rising edges.
- `o_start_n`  out  1  to divider `i_start_n`; active-low, one cycle wide.
- `i_sclk`  in  1  from divider `o_clk`; synchronous to `i_clk`.
- `i_sclk_idle`  in  1  from divider `o_idle`.
- `o_sclk`  out  1  SPI SCLK pad; `i_sclk` passed through combinationally.
- `o_cs_n`  out  1  SPI chip select, active-low.
- `o_mosi`  out  1  SPI MOSI.
- `i_miso`  in  1  SPI MISO; synchronous to `i_clk`, no synchroniser in this block.

## Operation
Reset values: `o_tx_ready`=0 while `i_rst` is high and 1 in the first cycle after release. `o_cs_n`=1, `o_start_n`=1, `o_mosi`=0, `o_rx_data`=0, `o_rx_valid`=0, `o_rx_err`=0. Internal state is IDLE with all counters at 0.

Edge detect:
- `sclk_q` registers `i_sclk` each cycle.
- rise = `i_sclk & ~sclk_q`; fall = `~i_sclk & sclk_q`.

States:
- IDLE: `o_tx_ready`=1, `o_cs_n`=1.
  - A handshake (`i_tx_valid & o_tx_ready`) latches `i_tx_data` into `tx_sr`, drives `o_mosi`=bit 7, loads `cnt`=`CS_SETUP_CYCLES`, and moves to SETUP.
- SETUP: `o_cs_n`=0; `cnt` decrements. When `cnt` reaches 1, move to START.
- START: wait until `i_sclk_idle`=1, then drive `o_start_n`=0 for exactly one cycle. Clear `bit_cnt` and `seen_busy`, then move to SHIFT.
- SHIFT:
  - `seen_busy` sets on any cycle with `i_sclk_idle`=0.
  - On rise: `rx_sr <= {rx_sr[6:0], i_miso}`; `bit_cnt` increments, saturating at 15.
  - On fall with `bit_cnt`<8: shift `tx_sr` left and drive `o_mosi` = new bit 7.
  - When `seen_busy` & `i_sclk_idle`: load `cnt`=`CS_HOLD_CYCLES` and move to HOLD.
- HOLD: `o_cs_n`=0; `cnt` decrements. When it reaches 1:
  - `o_cs_n`=1 next cycle.
  - `o_rx_data` <= `rx_sr`, `o_rx_valid`=1, `o_rx_err` = (`bit_cnt`≠8).
  - Return to IDLE.

Boundary rules:
- `o_tx_ready` is 0 in every state except IDLE. `i_tx_valid` during a transfer is ignored and not queued.
- Back-to-back: a handshake in the cycle `o_rx_valid` is high is impossible (`o_tx_ready` is still 0). The earliest next accept is the following cycle.
- `bit_cnt`=8 at the divider's idle is the only error-free outcome. Premature or late idle completes normally with `o_rx_err`=1; the block never hangs provided the divider eventually idles.
- `i_rst` mid-transfer returns all outputs to their reset values immediately. The divider is not reset by this block and finishes its burst with CS high.
- Correct operation requires a divider divisor ≥2, so each SCLK level lasts at least 1 `i_clk` cycle.

## Timing
- Handshake at edge N: `o_cs_n` falls after N; `o_mosi` is valid after N.
- With `i_sclk_idle`=1, `o_start_n` is low for the cycle following `CS_SETUP_CYCLES` cycles of CS low.
- MOSI changes one `i_clk` after each SCLK fall. MISO is captured on the `i_clk` edge where the rise is detected.
- The transfer spans divisor×8 `i_clk` cycles of divider activity.
- `o_rx_valid` rises `CS_HOLD_CYCLES` cycles after the HOLD state is entered; `o_cs_n` rises in the same cycle.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum {IDLE, SETUP, START, SHIFT, HOLD}.
  - `localparam SPI_WORD_BITS = 8`.
  - `localparam SPI_CNT_W = 8`.
- Sub-module `spi_edge_detect`: 1-bit registered previous value; outputs rise/fall.
- Everything else lives in a single FSM module.

## Test plan
- Nominal: divider configured {4,1}; send 0xA5 while the MISO model returns 0x3C. MOSI at the 8 rises must read 1,0,1,0,0,1,0,1. Response: `o_rx_data`=0x3C, `o_rx_err`=0, exactly one `o_rx_valid` pulse.
- Divisor 2, default parameters: send 0xFF, then 0x00 back-to-back with `i_tx_valid` held. Response: two accepts, CS high for at least 1 cycle between frames, received bytes match the MISO model.
- CS timing with `CS_SETUP_CYCLES`=5 and `CS_HOLD_CYCLES`=3. Response:
  - exactly 5 cycles of CS low before `o_start_n`=0;
  - `o_start_n` low for exactly 1 cycle;
  - exactly 3 cycles from divider idle to `o_cs_n`=1.
- Busy rejection: pulse `i_tx_valid` with 0x12 during SHIFT. Response: `o_tx_ready`=0, no second transfer, `o_rx_valid` count = 1.
- Error: a fake divider drives only 5 SCLK periods, then idles. Response: `o_rx_valid`=1 with `o_rx_err`=1, followed by a return to IDLE.
- Reset mid-SHIFT: assert `i_rst` after 3 rises. Response: `o_cs_n`=1, `o_mosi`=0, `o_start_n`=1, `o_rx_valid`=0 immediately. After release, the next 0x5A transfer completes cleanly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI mode-0 byte transceiver.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } spi_state_t;

  localparam int SPI_WORD_BITS = 8;
  localparam int SPI_CNT_W     = 8;

endpackage

// File: rtl/spi_transceiver_edge_detect.sv
// Registered previous value of a 1-bit signal with rise/fall strobes.
module spi_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig_q;

  // previous-cycle copy of the input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_q;
  assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/spi_transceiver.sv
// SPI mode-0 byte engine: frames a host byte with CS, triggers the SCLK
// divider, shifts MOSI out MSB-first and returns the MISO byte.
module spi_transceiver
  import spi_pkg::*;
#(
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [SPI_WORD_BITS-1:0] i_tx_data,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  output logic [SPI_WORD_BITS-1:0] o_rx_data,
  output logic                     o_rx_valid,
  output logic                     o_rx_err,
  output logic                     o_start_n,
  input  logic                     i_sclk,
  input  logic                     i_sclk_idle,
  output logic                     o_sclk,
  output logic                     o_cs_n,
  output logic                     o_mosi,
  input  logic                     i_miso
);

  localparam logic [SPI_CNT_W-1:0] L_SETUP = SPI_CNT_W'(CS_SETUP_CYCLES);
  localparam logic [SPI_CNT_W-1:0] L_HOLD  = SPI_CNT_W'(CS_HOLD_CYCLES);

  spi_state_t               r_state;
  logic [SPI_CNT_W-1:0]     r_cnt;
  logic [3:0]               r_bit_cnt;
  logic                     r_seen_busy;
  logic [SPI_WORD_BITS-2:0] r_tx_sr;
  logic [SPI_WORD_BITS-1:0] r_rx_sr;
  logic                     r_tx_ready;
  logic                     r_cs_n;
  logic                     r_start_n;
  logic                     r_mosi;
  logic [SPI_WORD_BITS-1:0] r_rx_data;
  logic                     r_rx_valid;
  logic                     r_rx_err;

  logic w_rise;
  logic w_fall;
  logic w_handshake;
  logic w_fire;

  spi_edge_detect u_sclk_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_handshake = i_tx_valid & r_tx_ready;
  // Start is issued on leaving SETUP when the divider is already idle, else from START once it idles.
  assign w_fire = i_sclk_idle &
                  (((r_state == SETUP) && (r_cnt <= 8'd1)) ||
                   ((r_state == START) && r_start_n));

  // transfer sequencer and all registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= 4'd0;
      r_seen_busy <= 1'b0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_tx_ready  <= 1'b0;
      r_cs_n      <= 1'b1;
      r_start_n   <= 1'b1;
      r_mosi      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_start_n  <= 1'b1;
      if (w_fire) begin
        r_start_n   <= 1'b0;
        r_bit_cnt   <= 4'd0;
        r_seen_busy <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_tx_ready <= ~w_handshake;
          if (w_handshake) begin
            r_tx_sr <= i_tx_data[SPI_WORD_BITS-2:0];
            r_mosi  <= i_tx_data[SPI_WORD_BITS-1];
            r_cnt   <= L_SETUP;
            r_cs_n  <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            r_state <= START;
          end
        end
        START: begin
          if (!r_start_n) begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!i_sclk_idle) begin
            r_seen_busy <= 1'b1;
          end
          if (w_rise) begin
            r_rx_sr <= {r_rx_sr[SPI_WORD_BITS-2:0], i_miso};
            if (r_bit_cnt != 4'd15) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          if (w_fall && (r_bit_cnt < 4'd8)) begin
            r_mosi  <= r_tx_sr[SPI_WORD_BITS-2];
            r_tx_sr <= {r_tx_sr[SPI_WORD_BITS-3:0], 1'b0};
          end
          if (r_seen_busy && i_sclk_idle) begin
            r_cnt   <= L_HOLD;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt <= 8'd1) begin
            r_cs_n     <= 1'b1;
            r_rx_data  <= r_rx_sr;
            r_rx_valid <= 1'b1;
            r_rx_err   <= (r_bit_cnt != 4'd8);
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cs_n     <= 1'b1;
          r_tx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_err   = r_rx_err;
  assign o_start_n  = r_start_n;
  assign o_sclk     = i_sclk;
  assign o_cs_n     = r_cs_n;
  assign o_mosi     = r_mosi;

endmodule
